// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller for the MIPS MEM stage.
// One load/store in flight at a time over a valid/ready request channel.
// Supports byte/half/word accesses with little-endian lane selection and
// sign/zero extension of loads. WAIT_STATES extra cycles separate the
// accept from the one-cycle response pulse.
// Optional feature macro: DMEM_ALIGN_CHECK_EN -- when defined, misaligned
// accesses and the reserved size report rsp_err and leave memory untouched.
module dmem_ctrl #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam int         AW      = DEPTH_LOG2 + 2;
    localparam logic [3:0] WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;

    // Captured request (only the address bits that reach the array).
    logic          cap_we;
    logic [1:0]    cap_size;
    logic          cap_signed;
    logic [AW-1:0] cap_addr;
    logic [31:0]   cap_wdata;

    // Request fields as seen on the commit edge.
    logic          cur_we;
    logic [1:0]    cur_size;
    logic          cur_signed;
    logic [AW-1:0] cur_addr;
    logic [31:0]   cur_wdata;

    logic                  accept;
    logic                  commit;
    logic                  fault;
    logic [DEPTH_LOG2-1:0] idx;
    logic [3:0]            be;
    logic [31:0]           st_data;
    logic [31:0]           rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           ld_ext;
    logic [31:0]           rdata_nxt;

    // Upper address bits alias onto the array and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW];

    // Zero-initialised so simulation starts from a known array image.
    logic [31:0] mem [DEPTH] = '{default: '0};

    assign accept = req_valid && req_ready;

    // Next-state / handshake outputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WS_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The edge entering RESP is the only edge that touches the array or
    // the response registers; a reset on that edge cancels it.
    assign commit = !rst && (state != S_RESP) && (state_nxt == S_RESP);

    // With zero wait states the commit edge is the accept edge, so the live
    // request is used; otherwise the captured copy is.
    always_comb begin
        if (state == S_IDLE) begin
            cur_we     = req_we;
            cur_size   = req_size;
            cur_signed = req_signed;
            cur_addr   = req_addr[AW-1:0];
            cur_wdata  = req_wdata;
        end else begin
            cur_we     = cap_we;
            cur_size   = cap_size;
            cur_signed = cap_signed;
            cur_addr   = cap_addr;
            cur_wdata  = cap_wdata;
        end
    end

    assign idx = cur_addr[AW-1:2];

    // Alignment policy: fault detection, or silently ignore low address bits.
    always_comb begin
`ifdef DMEM_ALIGN_CHECK_EN
        fault = (cur_size == 2'b11) ||
                ((cur_size == SZ_HALF) && cur_addr[0]) ||
                ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00));
`else
        fault = 1'b0;
`endif
    end

    // Store lane enables and lane-replicated write data.
    always_comb begin
        be      = 4'b1111;
        st_data = cur_wdata;
        case (cur_size)
            SZ_BYTE: begin
                be      = 4'b0001 << cur_addr[1:0];
                st_data = {4{cur_wdata[7:0]}};
            end
            SZ_HALF: begin
                be      = cur_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{cur_wdata[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                st_data = cur_wdata;
            end
        endcase
    end

    // Load path: pick the lane(s), shift to bit 0, extend.
    always_comb begin
        rd_word = mem[idx];
        case (cur_addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (cur_size)
            SZ_BYTE: ld_ext = {{24{cur_signed & rd_byte[7]}}, rd_byte};
            SZ_HALF: ld_ext = {{16{cur_signed & rd_half[15]}}, rd_half};
            default: ld_ext = rd_word;
        endcase
        rdata_nxt = (cur_we || fault) ? 32'd0 : ld_ext;
    end

    // FSM state, wait counter and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (commit) begin
                rsp_rdata <= rdata_nxt;
                rsp_err   <= fault;
            end
        end
    end

    // Capture the request at accept; inputs are don't-care afterwards.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_we     <= req_we;
            cap_size   <= req_size;
            cap_signed <= req_signed;
            cap_addr   <= req_addr[AW-1:0];
            cap_wdata  <= req_wdata;
        end
    end

    // Byte-lane writes on the commit edge; faulting stores write nothing.
    always_ff @(posedge clk) begin
        if (commit && cur_we && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: table-driven check of dmem_ctrl (WAIT_STATES=1) plus
// hand-written sequences for reset, mid-operation reset and back-to-back
// traffic on a WAIT_STATES=0 instance.
module tb_dmem_ctrl;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WAIT_STATES=1 instance
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    // WAIT_STATES=0 instance
    logic        req_valid0, req_ready0, req_we0, req_signed0;
    logic [1:0]  req_size0;
    logic [31:0] req_addr0, req_wdata0;
    logic        rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

    dmem_ctrl #(.DEPTH_LOG2(10), .WAIT_STATES(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    dmem_ctrl #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_size(req_size0), .req_signed(req_signed0), .req_addr(req_addr0),
        .req_wdata(req_wdata0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
        .rsp_err(rsp_err0)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    // Issue one request starting at a negedge, check latency, data, error
    // and that the pulse is one cycle wide. Ends at a negedge in IDLE.
    task automatic do_req(input vec_t v, input bit d0, input string tag);
        int n;
        logic rv;
        n = 0;
        while (!(d0 ? req_ready0 : req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        if (d0) begin
            req_valid0 = 1'b1; req_we0 = v.we; req_size0 = v.size;
            req_signed0 = v.sgn; req_addr0 = v.addr; req_wdata0 = v.wdata;
        end else begin
            req_valid = 1'b1; req_we = v.we; req_size = v.size;
            req_signed = v.sgn; req_addr = v.addr; req_wdata = v.wdata;
        end
        @(negedge clk);
        // Scramble the inputs after accept; the DUT must use its captured copy.
        if (d0) begin
            req_valid0 = 1'b0; req_we0 = ~v.we; req_size0 = ~v.size;
            req_signed0 = ~v.sgn; req_addr0 = ~v.addr; req_wdata0 = ~v.wdata;
        end else begin
            req_valid = 1'b0; req_we = ~v.we; req_size = ~v.size;
            req_signed = ~v.sgn; req_addr = ~v.addr; req_wdata = ~v.wdata;
        end
        n  = 1;
        rv = d0 ? rsp_valid0 : rsp_valid;
        while (!rv && n < 20) begin
            @(negedge clk);
            n++;
            rv = d0 ? rsp_valid0 : rsp_valid;
        end
        chk({tag, "_latency"}, 32'(n), d0 ? 32'd1 : 32'd2);
        chk({tag, "_rdata"}, d0 ? rsp_rdata0 : rsp_rdata, v.exp_rdata);
        chk({tag, "_err"}, {31'd0, d0 ? rsp_err0 : rsp_err}, {31'd0, v.exp_err});
        @(negedge clk);
        chk({tag, "_pulse_end"}, {31'd0, d0 ? rsp_valid0 : rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_size0 = 2'b00; req_signed0 = 1'b0;
        req_addr0 = 32'd0; req_wdata0 = 32'd0;

        // Stimulus table: {we, size, signed, addr, wdata, exp_rdata, exp_err}
        tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10,   32'h11223344, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, 32'h13,   32'h0, 32'h00000011, 1'b0));
        tbl.push_back(mk(1'b0, 2'b01, 1'b1, 32'h12,   32'h0, 32'h00001122, 1'b0));
        tbl.push_back(mk(1'b1, 2'b00, 1'b0, 32'h21,   32'hAAAAAAF0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h20,   32'h0, 32'h0000F000, 1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 1'b1, 32'h21,   32'h0, 32'hFFFFFFF0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b01, 1'b1, 32'h20,   32'h0, 32'hFFFFF000, 1'b0));
        tbl.push_back(mk(1'b0, 2'b01, 1'b0, 32'h20,   32'h0, 32'h0000F000, 1'b0));
        tbl.push_back(mk(1'b1, 2'b01, 1'b0, 32'h52,   32'h5A5A8001, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 2'b10, 1'b1, 32'h50,   32'h0, 32'h80010000, 1'b0));
        tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h1050, 32'h0, 32'h80010000, 1'b0));
        tbl.push_back(mk(1'b0, 2'b01, 1'b1, 32'h52,   32'h0, 32'hFFFF8001, 1'b0));
        tbl.push_back(mk(1'b0, 2'b00, 1'b0, 32'h10,   32'h0, 32'h00000044, 1'b0));
        tbl.push_back(mk(1'b1, 2'b01, 1'b0, 32'h31,   32'h1234BEEF, 32'h0, ALIGN));
        tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h30,   32'h0, ALIGN ? 32'h0 : 32'h0000BEEF, 1'b0));
        tbl.push_back(mk(1'b0, 2'b11, 1'b0, 32'h10,   32'h0, ALIGN ? 32'h0 : 32'h11223344, ALIGN));
        tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h12,   32'h0, ALIGN ? 32'h0 : 32'h11223344, ALIGN));
        tbl.push_back(mk(1'b1, 2'b10, 1'b0, 32'h62,   32'h01020304, 32'h0, ALIGN));
        tbl.push_back(mk(1'b0, 2'b10, 1'b0, 32'h60,   32'h0, ALIGN ? 32'h0 : 32'h01020304, 1'b0));

        // Reset held for 3 cycles: no handshake, no response.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_rsp_valid_%0d", i), {31'd0, rsp_valid}, 32'd0);
            chk($sformatf("rst_req_ready_%0d", i), {31'd0, req_ready}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("post_rst_ready0", {31'd0, req_ready0}, 32'd1);
        chk("post_rst_rdata", rsp_rdata, 32'd0);
        chk("post_rst_err", {31'd0, rsp_err}, 32'd0);
        chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);

        // Table vectors, back to back (each load issues in the IDLE cycle
        // right after the previous response).
        for (int i = 0; i < tbl.size(); i++) begin
            do_req(tbl[i], 1'b0, $sformatf("vec%0d", i));
        end

        // Reset on the commit edge of a store: dropped, nothing written.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid_after", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_ready_after", {31'd0, req_ready}, 32'd1);
        do_req(mk(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0), 1'b0, "midrst_load");

        // Zero wait states: single store then a held-valid load stream.
        do_req(mk(1'b1, 2'b10, 1'b0, 32'h8, 32'hCAFEF00D, 32'h0, 1'b0), 1'b1, "ws0_store");
        req_valid0 = 1'b1; req_we0 = 1'b0; req_size0 = 2'b10; req_signed0 = 1'b0;
        req_addr0 = 32'h8; req_wdata0 = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_valid_%0d", i), {31'd0, rsp_valid0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("b2b_ready_%0d", i), {31'd0, req_ready0}, (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i % 2 == 0) chk($sformatf("b2b_rdata_%0d", i), rsp_rdata0, 32'hCAFEF00D);
        end
        req_valid0 = 1'b0;
        @(negedge clk);
        chk("b2b_idle", {31'd0, rsp_valid0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
